// File: rtl/aes_block_serializer.sv
// Splits DATA_W-bit blocks into WORD_W-bit words over a valid/ready stream.
// A one-block pending buffer lets the next block load with no bubble between blocks.
module aes_block_serializer #(
   parameter int DATA_W    = 128,
   parameter int WORD_W    = 32,
   parameter int MSB_FIRST = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy
);

   localparam int N     = DATA_W / WORD_W;
   localparam int CNT_W = $clog2(N + 1);
   localparam logic [CNT_W-1:0] CNT_N   = CNT_W'(N);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   generate
      if ((DATA_W % WORD_W) != 0 || N < 2) begin : g_bad_params
         $error("aes_block_serializer: DATA_W must be a multiple of WORD_W with at least 2 words");
      end
   endgenerate

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] sr_reg, sr_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] pb_reg, pb_next;
   logic              pb_valid_reg, pb_valid_next;

   logic              in_fire;
   logic              out_fire;
   logic              last_fire;
   logic [DATA_W-1:0] sr_shifted;

   assign in_ready  = !pb_valid_reg;
   assign out_valid = (state_reg == SHIFT);
   assign out_last  = (state_reg == SHIFT) && (cnt_reg == CNT_ONE);
   assign busy      = (state_reg == SHIFT) || pb_valid_reg;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign last_fire = out_fire && (cnt_reg == CNT_ONE);

   // The emitting end of SR is fixed; words move toward it and zeros fill in behind.
   generate
      if (MSB_FIRST != 0) begin : g_msb
         assign out_data   = sr_reg[DATA_W-1 -: WORD_W];
         assign sr_shifted = sr_reg << WORD_W;
      end else begin : g_lsb
         assign out_data   = sr_reg[WORD_W-1:0];
         assign sr_shifted = sr_reg >> WORD_W;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg    <= IDLE;
         sr_reg       <= '0;
         cnt_reg      <= '0;
         pb_reg       <= '0;
         pb_valid_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         sr_reg       <= sr_next;
         cnt_reg      <= cnt_next;
         pb_reg       <= pb_next;
         pb_valid_reg <= pb_valid_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      sr_next       = sr_reg;
      cnt_next      = cnt_reg;
      pb_next       = pb_reg;
      pb_valid_next = pb_valid_reg;

      case (state_reg)
         IDLE: begin
            if (in_fire) begin
               sr_next    = in_data;
               cnt_next   = CNT_N;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (out_fire) begin
               if (cnt_reg > CNT_ONE) begin
                  sr_next  = sr_shifted;
                  cnt_next = cnt_reg - CNT_ONE;
               end else if (pb_valid_reg) begin
                  sr_next       = pb_reg;
                  pb_valid_next = 1'b0;
                  cnt_next      = CNT_N;
               end else if (in_fire) begin
                  // Pending buffer empty: the new block goes straight into SR.
                  sr_next  = in_data;
                  cnt_next = CNT_N;
               end else begin
                  sr_next    = '0;
                  cnt_next   = '0;
                  state_next = IDLE;
               end
            end
            if (in_fire && !last_fire) begin
               pb_next       = in_data;
               pb_valid_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_block_serializer.sv
// Scoreboard bench: accepted blocks push expected words; a negedge monitor pops on each handshake.
module tb_aes_block_serializer;

   logic         clk;
   logic         reset;
   logic [127:0] in_data;
   logic         in_valid;
   logic         out_ready;
   logic         in_ready_a, in_ready_b;
   logic [31:0]  out_data_a, out_data_b;
   logic         out_valid_a, out_valid_b;
   logic         out_last_a, out_last_b;
   logic         busy_a, busy_b;

   logic [63:0]  in_data_c;
   logic         in_valid_c;
   logic         out_ready_c;
   logic         in_ready_c;
   logic [7:0]   out_data_c;
   logic         out_valid_c;
   logic         out_last_c;
   logic         busy_c;

   logic [32:0]  q_a[$];
   logic [32:0]  q_b[$];
   logic [8:0]   q_c[$];

   int n_checks = 0;
   int n_pass   = 0;
   int run_len  = 0;
   int last_run = 0;

   aes_block_serializer dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
      .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_last(out_last_a), .busy(busy_a)
   );

   aes_block_serializer #(.MSB_FIRST(0)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
      .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_last(out_last_b), .busy(busy_b)
   );

   aes_block_serializer #(.DATA_W(64), .WORD_W(8)) dut_c (
      .clk(clk), .reset(reset), .in_data(in_data_c), .in_valid(in_valid_c), .in_ready(in_ready_c),
      .out_data(out_data_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
      .out_last(out_last_c), .busy(busy_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: one scoreboard pop per output handshake, plus a run-length tracker on dut_a.
   always @(negedge clk) begin
      if (reset) begin
         run_len = 0;
      end else begin
         if (out_valid_a) run_len++;
         else if (run_len != 0) begin
            last_run = run_len;
            run_len  = 0;
         end
         if (out_valid_a && out_ready) begin
            if (q_a.size() == 0) begin
               n_checks++;
               $display("FAIL a_unexpected_word: got %h expected none", out_data_a);
            end else chk("a_word", {95'd0, out_last_a, out_data_a}, {95'd0, q_a.pop_front()});
            $display("word a: %h last=%0b", out_data_a, out_last_a);
         end
         if (out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
               n_checks++;
               $display("FAIL b_unexpected_word: got %h expected none", out_data_b);
            end else chk("b_word", {95'd0, out_last_b, out_data_b}, {95'd0, q_b.pop_front()});
         end
         if (out_valid_c && out_ready_c) begin
            if (q_c.size() == 0) begin
               n_checks++;
               $display("FAIL c_unexpected_word: got %h expected none", out_data_c);
            end else chk("c_word", {119'd0, out_last_c, out_data_c}, {119'd0, q_c.pop_front()});
            $display("word c: %h last=%0b", out_data_c, out_last_c);
         end
      end
   end

   task automatic expect_block(input logic [127:0] blk);
      for (int i = 0; i < 4; i++) begin
         q_a.push_back({i == 3, blk[127-32*i -: 32]});
         q_b.push_back({i == 3, blk[32*i +: 32]});
      end
   endtask

   task automatic offer(input logic [127:0] blk, output int waits);
      waits    = 0;
      in_data  = blk;
      in_valid = 1'b1;
      while (!in_ready_a && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      if (in_ready_a) begin
         expect_block(blk);
         @(posedge clk); #1;
      end else begin
         n_checks++;
         $display("FAIL offer_timeout: in_ready stayed 0 for %0d cycles, required 1", waits);
      end
      in_valid = 1'b0;
      in_data  = '1;
   endtask

   task automatic drain;
      int guard;
      guard = 0;
      while (guard < 60 && !(q_a.size() == 0 && q_b.size() == 0 && q_c.size() == 0
                             && !out_valid_a && !out_valid_c)) begin
         @(negedge clk); #1;
         guard++;
      end
      if (guard >= 60) begin
         n_checks++;
         $display("FAIL drain_timeout: %0d words left, required 0", q_a.size() + q_b.size() + q_c.size());
      end
      @(posedge clk); #1;
   endtask

   localparam logic [127:0] BLK_K = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] BLK_1 = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
   localparam logic [127:0] BLK_2 = 128'h11111111_22222222_33333333_44444444;
   localparam logic [127:0] BLK_3 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;

   initial begin
      int w;
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b1;
      in_valid_c  = 1'b0;
      in_data_c   = '0;
      out_ready_c = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", out_valid_a, 1'b0);
      chk("rst_out_data",  out_data_a, 32'h0);
      chk("rst_out_last",  out_last_a, 1'b0);
      chk("rst_busy",      busy_a, 1'b0);
      chk("rst_in_ready",  in_ready_a, 1'b1);
      chk("rst_c_in_ready", in_ready_c, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Single block, MSB-first and LSB-first instances in lockstep.
      offer(BLK_K, w);
      drain();
      chk("single_run_len", last_run, 4);
      chk("single_idle_busy", busy_a, 1'b0);
      $display("single block done: run=%0d", last_run);

      // Three blocks back-to-back: 12 words without a gap, in_ready low while PB full.
      offer(BLK_1, w);
      offer(BLK_2, w);
      chk("b2b_second_waits", w, 0);
      offer(BLK_3, w);
      chk("b2b_third_waits", w, 3);
      drain();
      chk("b2b_run_len", last_run, 12);
      $display("back-to-back done: run=%0d", last_run);

      // Next block offered exactly on the last-word edge with PB empty.
      offer(BLK_K, w);
      for (int i = 0; i < 10 && !out_last_a; i++) @(negedge clk);
      offer(BLK_1, w);
      chk("bubble_waits", w, 0);
      drain();
      chk("bubble_run_len", last_run, 8);
      $display("zero-bubble done: run=%0d", last_run);

      // Downstream stall on word 1 for 5 cycles while PB fills.
      offer(BLK_K, w);
      @(posedge clk); #1;
      out_ready = 1'b0;
      offer(BLK_2, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_a_data", out_data_a, 32'h44556677);
         chk("stall_b_data", out_data_b, 32'h8899AABB);
         chk("stall_last",   out_last_a, 1'b0);
         chk("stall_in_ready", in_ready_a, 1'b0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      drain();
      $display("stall done");

      // Async reset while word 2 is showing and PB is full.
      offer(BLK_K, w);
      offer(BLK_3, w);
      @(posedge clk); #3;
      reset = 1'b1;
      q_a.delete();
      q_b.delete();
      #1;
      chk("midrst_out_valid", out_valid_a, 1'b0);
      chk("midrst_busy",      busy_a, 1'b0);
      chk("midrst_b_busy",    busy_b, 1'b0);
      chk("midrst_out_data",  out_data_a, 32'h0);
      chk("midrst_in_ready",  in_ready_a, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      offer(BLK_2, w);
      drain();
      chk("post_rst_run_len", last_run, 4);
      $display("mid-block reset done");

      // 64-bit block into 8-bit words.
      in_data_c  = 64'h01020304_05060708;
      in_valid_c = 1'b1;
      chk("c_in_ready", in_ready_c, 1'b1);
      for (int i = 0; i < 8; i++) q_c.push_back({i == 7, 8'(i + 1)});
      @(posedge clk); #1;
      in_valid_c = 1'b0;
      in_data_c  = '1;
      drain();
      chk("c_idle_busy", busy_c, 1'b0);
      $display("narrow instance done");

      chk("final_q_a_empty", q_a.size(), 0);
      chk("final_q_b_empty", q_b.size(), 0);
      chk("final_q_c_empty", q_c.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_block_serializer.md
AES_BLOCK_SERIALIZER -- requirements
Module: aes_block_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 128, meaning input block width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning output word width in bits.
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 = emit the most-significant word first, 0 = emit the least-significant word first.
REQ-004 SHALL define N = DATA_W/WORD_W; DATA_W SHALL be an exact multiple of WORD_W and N SHALL be at least 2, with elaboration failing otherwise.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 in_data  input  DATA_W  block to serialize.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block is accepted on any edge where in_valid && in_ready.
REQ-010 out_data  output  WORD_W  current output word.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  downstream accepts the word on any edge where out_valid && out_ready.
REQ-013 out_last  output  1  current word is the final word (word N-1) of its block.
REQ-014 busy  output  1  shift register or pending buffer is occupied.

Function
REQ-015 SHALL hold two storage stages: a shift register (SR) with a word counter, and a one-block pending buffer (PB) with a valid flag.
REQ-016 SHALL implement two states: IDLE (SR empty) and SHIFT (SR holds 1..N remaining words).
REQ-017 in_ready SHALL equal !PB_valid, with no combinational path from out_ready.
REQ-018 out_valid SHALL be 1 exactly when the state is SHIFT.
REQ-019 out_data SHALL be SR[DATA_W-1 -: WORD_W] when MSB_FIRST=1, and SR[WORD_W-1:0] when MSB_FIRST=0.
REQ-020 IDLE, input accepted: SHALL load SR with in_data, set the count to N, and enter SHIFT; the first word SHALL appear in the cycle after acceptance (latency 1).
REQ-021 SHIFT, input accepted, and no last-word handoff this edge: the block SHALL be written into PB.
REQ-022 SHIFT, word handshake with count > 1: SHALL shift SR by WORD_W toward the emitting end, zero-fill the vacated word, and decrement the count.
REQ-023 out_last SHALL equal (state == SHIFT && count == 1).
REQ-024 Last-word handshake with PB_valid: SHALL load SR from PB, clear PB_valid, set the count to N, and stay in SHIFT.
REQ-025 Last-word handshake, PB empty, input accepted on the same edge: SHALL load SR directly from in_data and stay in SHIFT (zero bubble).
REQ-026 Last-word handshake, PB empty, no input: SHALL go to IDLE and clear SR.
REQ-027 Back-to-back blocks SHALL stream at 1 word per cycle with no idle cycle between blocks when out_ready is held at 1.
REQ-028 While out_valid && !out_ready, out_data, out_last and the count SHALL remain stable.
REQ-029 in_data SHALL be ignored whenever in_valid && in_ready is false.
REQ-030 busy SHALL equal (state == SHIFT) || PB_valid.

Reset
REQ-031 While reset is asserted: state=IDLE, SR=0, count=0, PB=0, PB_valid=0.
REQ-032 Resulting outputs during and after reset: out_valid=0, out_data=0, out_last=0, busy=0, in_ready=1.
REQ-033 Reset asserted mid-block SHALL discard all SR and PB contents immediately, with no further words emitted.

Verification
REQ-034 Defaults; reset; then accept in_data=0x00112233_44556677_8899AABB_CCDDEEFF with out_ready=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, out_last only on the 4th, then IDLE.
REQ-035 MSB_FIRST=0, same block -> CCDDEEFF, 8899AABB, 44556677, 00112233 in that order.
REQ-036 Three blocks offered back-to-back, out_ready=1 -> 12 consecutive valid words with no gap; in_ready=0 exactly while PB is full.
REQ-037 out_ready held at 0 for 5 cycles mid-block -> out_data stable, no word lost or duplicated; in_ready=0 once PB has filled.
REQ-038 Reset pulse during word 2 with PB full -> out_valid=0 and busy=0 immediately; the next accepted block starts from its word 0.
REQ-039 DATA_W=64, WORD_W=8 -> 8 words per block, out_last on the 8th; the 0x0102030405060708 block yields 01..08.
